xip_ahbl_ctrl: RTL and testbench

AHB-Lite slave front end for the quad-SPI execute-in-place flash path; sits directly upstream of the direct-mapped line cache and the flash line reader.
- Decodes read transfers and pre-checks cache hit during the address phase.
- Serves hits with zero wait states.
- On a miss, holds the bus, requests one line from the flash reader, strobes the cache write, then returns the word.
- Read-only; write transfers get an AHB ERROR response.

---
 rtl/xip_pkg.sv | 28 ++
 rtl/xip_perf_cnt.sv | 29 ++
 rtl/xip_ahbl_ctrl.sv | 128 ++++++++++++
 tb/tb_xip_ahbl_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xip_pkg.sv
// rtl/xip_pkg.sv - shared FSM state encoding and AHB-Lite constants for the XIP front end
package xip_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HIT  = 3'd1,
      ST_REQ  = 3'd2,
      ST_WAIT = 3'd3,
      ST_FILL = 3'd4,
      ST_DONE = 3'd5,
      ST_ERR1 = 3'd6,
      ST_ERR2 = 3'd7
   } xip_state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // NONSEQ and SEQ both carry bit 1; IDLE and BUSY never start a transfer
   function automatic logic is_valid_xfer(input logic sel, input logic [1:0] trans, input logic ready);
      return sel & trans[1] & ready;
   endfunction

endpackage

// File: rtl/xip_perf_cnt.sv
// rtl/xip_perf_cnt.sv - free-running 32-bit hit/miss counters for the XIP front end
module xip_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_hit_inc,
   input  logic        i_miss_inc,
   output logic [31:0] o_hit_cnt,
   output logic [31:0] o_miss_cnt
);

   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit_cnt  <= 32'd0;
         r_miss_cnt <= 32'd0;
      end else begin
         if (i_hit_inc)
            r_hit_cnt <= r_hit_cnt + 32'd1;
         if (i_miss_inc)
            r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign o_hit_cnt  = r_hit_cnt;
   assign o_miss_cnt = r_miss_cnt;

endmodule

// File: rtl/xip_ahbl_ctrl.sv
// rtl/xip_ahbl_ctrl.sv - AHB-Lite read-only XIP slave: zero-wait cache hits, line refill on miss
// Optional hit/miss counters under XIP_AHBL_CTRL_PERF_CNT_EN.
module xip_ahbl_ctrl
   import xip_pkg::*;
#(
   parameter int LINE_SIZE = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        HSEL,
   input  logic [1:0]  HTRANS,
   input  logic [31:0] HADDR,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA,
   output logic [23:0] cache_a,
   output logic [23:0] cache_a_h,
   input  logic        cache_hit,
   input  logic [31:0] cache_do,
   output logic        cache_wr,
   output logic [23:0] fr_addr,
   output logic        fr_rd,
`ifdef XIP_AHBL_CTRL_PERF_CNT_EN
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt,
`endif
   input  logic        fr_done
);

   localparam int OFF_WIDTH = $clog2(LINE_SIZE);

   xip_state_t  r_state;
   xip_state_t  w_next;
   logic [23:0] r_addr_q;
   logic        r_hit_q;
   logic        r_wr_q;
   logic        w_valid;
   logic        w_decode;

   assign w_valid  = is_valid_xfer(HSEL, HTRANS, HREADY);
   // Only states that present HREADYOUT=1 without an error own the overlapping address phase
   assign w_decode = (r_state == ST_IDLE) || (r_state == ST_HIT) || (r_state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr_q <= 24'd0;
         r_hit_q  <= 1'b0;
         r_wr_q   <= 1'b0;
      end else if (w_valid && w_decode) begin
         r_addr_q <= HADDR[23:0];
         r_hit_q  <= cache_hit;
         r_wr_q   <= HWRITE;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_HIT, ST_DONE: begin
            if (w_valid)
               w_next = HWRITE ? ST_ERR1 : (cache_hit ? ST_HIT : ST_REQ);
            else
               w_next = ST_IDLE;
         end
         ST_REQ:  w_next = ST_WAIT;
         ST_WAIT: w_next = fr_done ? ST_FILL : ST_WAIT;
         ST_FILL: w_next = ST_DONE;
         ST_ERR1: w_next = ST_ERR2;
         ST_ERR2: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      fr_rd     = 1'b0;
      cache_wr  = 1'b0;
      case (r_state)
         ST_REQ: begin
            HREADYOUT = 1'b0;
            fr_rd     = 1'b1;
         end
         ST_WAIT: HREADYOUT = 1'b0;
         ST_FILL: begin
            HREADYOUT = 1'b0;
            cache_wr  = 1'b1;
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
         end
         ST_ERR2: HRESP = HRESP_ERROR;
         default: ;
      endcase
   end

   assign HRDATA    = cache_do;
   assign cache_a   = r_addr_q;
   assign cache_a_h = HADDR[23:0];
   assign fr_addr   = {r_addr_q[23:OFF_WIDTH], {OFF_WIDTH{1'b0}}};

   // Captured hit/write flags are kept for observability of the last accepted transfer
   logic w_unused;
   assign w_unused = ^{HADDR[31:24], HSIZE, r_hit_q, r_wr_q};

`ifdef XIP_AHBL_CTRL_PERF_CNT_EN
   xip_perf_cnt u_perf_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_hit_inc  (w_next == ST_HIT),
      .i_miss_inc (w_next == ST_REQ),
      .o_hit_cnt  (hit_cnt),
      .o_miss_cnt (miss_cnt)
   );
`endif

endmodule

// File: tb/tb_xip_ahbl_ctrl.sv
// tb/tb_xip_ahbl_ctrl.sv - scoreboard bench for xip_ahbl_ctrl with cache and flash reader models
module tb_xip_ahbl_ctrl;

   localparam int SETS = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        HSEL;
   logic [1:0]  HTRANS;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic [23:0] cache_a;
   logic [23:0] cache_a_h;
   logic        cache_hit;
   logic [31:0] cache_do;
   logic        cache_wr;
   logic [23:0] fr_addr;
   logic        fr_rd;
   logic        fr_done;
`ifdef XIP_AHBL_CTRL_PERF_CNT_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   xip_ahbl_ctrl #(.LINE_SIZE(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .HSEL      (HSEL),
      .HTRANS    (HTRANS),
      .HADDR     (HADDR),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HREADY    (HREADY),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .cache_a   (cache_a),
      .cache_a_h (cache_a_h),
      .cache_hit (cache_hit),
      .cache_do  (cache_do),
      .cache_wr  (cache_wr),
      .fr_addr   (fr_addr),
      .fr_rd     (fr_rd),
`ifdef XIP_AHBL_CTRL_PERF_CNT_EN
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt),
`endif
      .fr_done   (fr_done)
   );

   always #5 clk = ~clk;
   assign HREADY = HREADYOUT;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Flash content: every word is a function of its word address, one word pinned for the directed hit
   function automatic logic [31:0] word_at(input logic [23:0] a);
      logic [23:0] w;
      w = {a[23:2], 2'b00};
      if (w == 24'h000104)
         return 32'hDEADBEEF;
      return {8'h5A, w};
   endfunction

   // Direct-mapped cache model: 16 lines of 16 bytes, tag = addr[23:8]
   logic [15:0] tag_arr [SETS];
   logic        vld     [SETS];
   bit          cache_init = 1'b0;
   int          n_cache_wr = 0;
   int          n_done_ok  = 0;

   function automatic logic model_hit(input logic [23:0] a);
      return vld[a[7:4]] && (tag_arr[a[7:4]] == a[23:8]);
   endfunction

   always_comb cache_hit = vld[cache_a_h[7:4]] && (tag_arr[cache_a_h[7:4]] == cache_a_h[23:8]);
   always_comb cache_do  = word_at(cache_a);

   always @(negedge clk) begin
      if (rst && !cache_init) begin
         for (int i = 0; i < SETS; i++) begin
            vld[i]     = 1'b0;
            tag_arr[i] = 16'h0;
         end
         vld[0]     = 1'b1;
         tag_arr[0] = 16'h0001;
         cache_init = 1'b1;
      end else if (!rst && cache_wr) begin
         chk("cache_wr_after_done", 32'(n_cache_wr < n_done_ok), 32'd1);
         n_cache_wr++;
         vld[cache_a[7:4]]     = 1'b1;
         tag_arr[cache_a[7:4]] = cache_a[23:8];
      end
   end

   typedef struct {
      logic [23:0] addr;
      bit          is_err;
      bit          hit;
      int          lat;
   } exp_t;

   typedef struct {
      logic [23:0] line;
      int          lat;
   } fr_t;

   exp_t exp_q[$];
   fr_t  fr_q[$];
   int   n_resets = 0;
   int   n_fr_rd  = 0;
   int   n_miss   = 0;
   int   m_hit    = 0;
   int   m_miss   = 0;

   // Flash reader: fr_done after lat quiet cycles; a reset in between voids the line
   initial begin
      fr_t f;
      int  rs;
      fr_done = 1'b0;
      forever begin
         @(negedge clk);
         if (fr_rd && !rst) begin
            n_fr_rd++;
            chk("fr_rd_expected", 32'(fr_q.size() != 0), 32'd1);
            if (fr_q.size() != 0) begin
               f = fr_q.pop_front();
               chk("fr_addr", {8'h0, fr_addr}, {8'h0, f.line});
               rs = n_resets;
               @(posedge clk); #1;
               repeat (f.lat) begin
                  @(posedge clk); #1;
               end
               fr_done = 1'b1;
               if (rs == n_resets)
                  n_done_ok++;
               @(posedge clk); #1;
               fr_done = 1'b0;
            end
         end
      end
   end

   // Monitor: pops one expectation per accepted transfer and grades its data phase
   exp_t cur;
   bit   pending = 1'b0;
   bit   start   = 1'b0;
   int   waits   = 0;

   always @(negedge clk) begin
      if (rst) begin
         pending = 1'b0;
         start   = 1'b0;
         exp_q.delete();
      end else begin
         if (start) begin
            start   = 1'b0;
            waits   = 0;
            pending = (exp_q.size() != 0);
            chk("sb_nonempty", 32'(pending), 32'd1);
            if (pending)
               cur = exp_q.pop_front();
         end
         if (pending) begin
            if (!HREADYOUT) begin
               waits++;
               if (cur.is_err && waits == 1)
                  chk("err1_hresp", 32'(HRESP), 32'd1);
            end else begin
               chk("resp", 32'(HRESP), 32'(cur.is_err));
               chk("wait_cycles", 32'(waits), 32'(cur.is_err ? 1 : (cur.hit ? 0 : cur.lat + 3)));
               if (!cur.is_err)
                  chk("hrdata", HRDATA, word_at(cur.addr));
               pending = 1'b0;
            end
         end else begin
            chk("idle_okay", {30'd0, HREADYOUT, HRESP}, 32'd2);
         end
         if (HSEL && HTRANS[1] && HREADY)
            start = 1'b1;
      end
   end

   task automatic issue(input logic [23:0] a, input bit wr, input int lat);
      exp_t e;
      fr_t  f;
      int   n;
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HADDR  = {8'($urandom), a};
      HWRITE = wr;
      HSIZE  = 3'($urandom);
      n = 0;
      forever begin
         @(negedge clk);
         if (HREADY)
            break;
         n++;
         if (n > 500) begin
            chk("accept_timeout", 32'd1, 32'd0);
            break;
         end
      end
      e.addr   = a;
      e.is_err = wr;
      e.hit    = !wr && model_hit(a);
      e.lat    = lat;
      exp_q.push_back(e);
      if (!wr) begin
         if (e.hit) begin
            m_hit++;
         end else begin
            m_miss++;
            n_miss++;
            f.line = a & ~24'hF;
            f.lat  = lat;
            fr_q.push_back(f);
         end
      end
      @(posedge clk); #1;
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      if (wr) begin
         repeat (2) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 2))
            0:       begin HSEL = 1'b0; HTRANS = 2'b10; end
            1:       begin HSEL = 1'b1; HTRANS = 2'b01; end
            default: begin HSEL = 1'b1; HTRANS = 2'b00; end
         endcase
         HADDR  = $urandom;
         HWRITE = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      HSEL   = 1'b0;
      HTRANS = 2'b00;
   endtask

   initial begin
      int nrd;
      int nwr;
      rst    = 1'b1;
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HADDR  = 32'h0;
      HWRITE = 1'b0;
      HSIZE  = 3'b010;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("rst_hresp", 32'(HRESP), 32'd0);
      chk("rst_fr_rd", 32'(fr_rd), 32'd0);
      chk("rst_cache_wr", 32'(cache_wr), 32'd0);
      chk("rst_cache_a", {8'h0, cache_a}, 32'h0);
      @(posedge clk); #1;

      issue(24'h000104, 1'b0, 0);
      idle(2);
      issue(24'h012345, 1'b0, 40);
      idle(50);

      issue(24'h000000, 1'b0, 3);
      issue(24'h000000, 1'b0, 0);
      issue(24'h000004, 1'b0, 0);
      issue(24'h000008, 1'b0, 0);
      issue(24'h00000C, 1'b0, 0);
      idle(2);

      nrd = n_fr_rd;
      nwr = n_cache_wr;
      issue(24'h000010, 1'b1, 0);
      idle(3);
      chk("err_no_fr_rd", 32'(n_fr_rd), 32'(nrd));
      chk("err_no_cache_wr", 32'(n_cache_wr), 32'(nwr));

      nwr = n_cache_wr;
      issue(24'h000200, 1'b0, 20);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      n_resets++;
      m_hit  = 0;
      m_miss = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("rstmid_fr_rd", 32'(fr_rd), 32'd0);
      chk("rstmid_cache_wr", 32'(cache_wr), 32'd0);
      @(posedge clk); #1;
      idle(30);
      chk("rstmid_no_fill", 32'(n_cache_wr), 32'(nwr));

      for (int i = 0; i < 80; i++) begin
         issue(24'($urandom_range(0, 2047)), ($urandom_range(0, 9) == 0), $urandom_range(0, 6));
         if ($urandom_range(0, 2) == 0)
            idle($urandom_range(1, 3));
      end
      idle(60);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      chk("no_pending", 32'(pending), 32'd0);
      chk("fr_rd_count", 32'(n_fr_rd), 32'(n_miss));
      chk("cache_wr_count", 32'(n_cache_wr), 32'(n_done_ok));
`ifdef XIP_AHBL_CTRL_PERF_CNT_EN
      chk("hit_cnt", hit_cnt, 32'(m_hit));
      chk("miss_cnt", miss_cnt, 32'(m_miss));
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
